// File: rtl/mby_mc_tag_ring_rx.sv
// Receive-side stop on the multicast tag ring. A tag whose mask includes
// MY_PORT is captured into a local show-ahead FIFO and forwarded with that
// bit cleared. If the FIFO is full, the slot is forwarded unchanged so the tag
// recirculates, and a saturating defer counter records the miss.
module mby_mc_tag_ring_rx #(
    parameter int NUM_PORTS = 16,
    parameter int MY_PORT   = 0,
    parameter int TAG_W     = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_ring_valid,
    input  logic [NUM_PORTS-1:0]       i_ring_mask,
    input  logic [TAG_W-1:0]           i_ring_tag,
    output logic                       o_ring_valid,
    output logic [NUM_PORTS-1:0]       o_ring_mask,
    output logic [TAG_W-1:0]           o_ring_tag,
    output logic                       o_tag_valid,
    input  logic                       i_tag_ready,
    output logic [TAG_W-1:0]           o_tag_data,
    output logic [$clog2(DEPTH):0]     o_fifo_level,
    output logic [CNT_W-1:0]           o_defer_cnt,
    input  logic                       i_defer_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [TAG_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [LVL_W-1:0]     level_reg;
    logic                 ring_valid_reg;
    logic [NUM_PORTS-1:0] ring_mask_reg;
    logic [TAG_W-1:0]     ring_tag_reg;
    logic [CNT_W-1:0]     defer_cnt_reg;

    logic                 hit;
    logic                 full;
    logic                 accept;
    logic                 defer;
    logic                 pop;
    logic [NUM_PORTS-1:0] fwd_mask;
    logic                 fwd_valid;

    // Full uses the registered level only, so a same-cycle pop never
    // influences the capture decision or any ring output.
    assign hit    = i_ring_valid & i_ring_mask[MY_PORT];
    assign full   = (level_reg == FULL_LVL);
    assign accept = hit & ~full;
    assign defer  = hit & full;
    assign pop    = o_tag_valid & i_tag_ready;

    // Only the owned mask bit is cleared, and only when the tag was taken.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_fwd
            if (gi == MY_PORT) begin : g_own
                assign fwd_mask[gi] = i_ring_mask[gi] & ~accept;
            end else begin : g_pass
                assign fwd_mask[gi] = i_ring_mask[gi];
            end
        end
    endgenerate

    assign fwd_valid = i_ring_valid & (fwd_mask != '0);

    // FIFO storage; pointer reset makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= i_ring_tag;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_reg + LVL_W'(accept) - LVL_W'(pop);
        end
    end

    // Registered ring stage; empty slots are squashed to all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_valid_reg <= 1'b0;
            ring_mask_reg  <= '0;
            ring_tag_reg   <= '0;
        end else begin
            ring_valid_reg <= fwd_valid;
            ring_mask_reg  <= fwd_valid ? fwd_mask : '0;
            ring_tag_reg   <= fwd_valid ? i_ring_tag : '0;
        end
    end

    // Saturating defer counter; a clear that coincides with a defer counts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            defer_cnt_reg <= '0;
        end else if (i_defer_clr) begin
            defer_cnt_reg <= defer ? CNT_W'(1) : '0;
        end else if (defer && (defer_cnt_reg != CNT_MAX)) begin
            defer_cnt_reg <= defer_cnt_reg + 1'b1;
        end
    end

    assign o_ring_valid = ring_valid_reg;
    assign o_ring_mask  = ring_mask_reg;
    assign o_ring_tag   = ring_tag_reg;
    assign o_tag_valid  = (level_reg != '0);
    assign o_tag_data   = o_tag_valid ? mem[rd_ptr_reg] : '0;
    assign o_fifo_level = level_reg;
    assign o_defer_cnt  = defer_cnt_reg;

endmodule

// File: tb/tb_mby_mc_tag_ring_rx.sv
// Self-checking bench for mby_mc_tag_ring_rx (MY_PORT=0, DEPTH=8, CNT_W=4).
// Expected captured tags are queued when the hit is driven and popped when the
// DUT presents them; ring outputs, level and defer count are checked per cycle.
module tb_mby_mc_tag_ring_rx;

    localparam int NP    = 16;
    localparam int TW    = 32;
    localparam int DEP   = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_ring_valid;
    logic [NP-1:0] i_ring_mask;
    logic [TW-1:0] i_ring_tag;
    logic          o_ring_valid;
    logic [NP-1:0] o_ring_mask;
    logic [TW-1:0] o_ring_tag;
    logic          o_tag_valid;
    logic          i_tag_ready;
    logic [TW-1:0] o_tag_data;
    logic [3:0]    o_fifo_level;
    logic [CW-1:0] o_defer_cnt;
    logic          i_defer_clr;

    mby_mc_tag_ring_rx #(
        .NUM_PORTS(NP), .MY_PORT(0), .TAG_W(TW), .DEPTH(DEP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_ring_valid(i_ring_valid), .i_ring_mask(i_ring_mask), .i_ring_tag(i_ring_tag),
        .o_ring_valid(o_ring_valid), .o_ring_mask(o_ring_mask), .o_ring_tag(o_ring_tag),
        .o_tag_valid(o_tag_valid), .i_tag_ready(i_tag_ready), .o_tag_data(o_tag_data),
        .o_fifo_level(o_fifo_level), .o_defer_cnt(o_defer_cnt), .i_defer_clr(i_defer_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [TW-1:0] exp_q[$];
    int            m_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One ring cycle: drive, check head before the edge, check registered outputs after.
    task automatic cyc(input logic v, input logic [NP-1:0] m, input logic [TW-1:0] t,
                       input logic rdy, input logic clr);
        logic          hit, full, acc, dfr, pp;
        logic [NP-1:0] fm;
        logic          fv;
        i_ring_valid = v; i_ring_mask = m; i_ring_tag = t;
        i_tag_ready = rdy; i_defer_clr = clr; rst = 1'b0;
        hit  = v & m[0];
        full = (exp_q.size() == DEP);
        acc  = hit & !full;
        dfr  = hit & full;
        pp   = (exp_q.size() != 0) & rdy;
        check("tag_valid", {63'd0, o_tag_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) check("tag_data", {32'd0, o_tag_data}, {32'd0, exp_q[0]});
        else                   check("tag_data_empty", {32'd0, o_tag_data}, 64'd0);
        if (pp) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(t);
        if (clr)                     m_cnt = dfr ? 1 : 0;
        else if (dfr && m_cnt != 15) m_cnt = m_cnt + 1;
        fm = acc ? (m & ~NP'(1)) : m;
        fv = v & (fm != 0);
        @(posedge clk); #1;
        $display("[TB] slot v=%0b m=%04h t=%08h rdy=%0b clr=%0b -> ov=%0b om=%04h lvl=%0d dcnt=%0d",
                 v, m, t, rdy, clr, o_ring_valid, o_ring_mask, o_fifo_level, o_defer_cnt);
        check("ring_valid", {63'd0, o_ring_valid}, {63'd0, fv});
        check("ring_mask", {48'd0, o_ring_mask}, fv ? {48'd0, fm} : 64'd0);
        check("ring_tag", {32'd0, o_ring_tag}, fv ? {32'd0, t} : 64'd0);
        check("level", {60'd0, o_fifo_level}, 64'(exp_q.size()));
        check("defer_cnt", {60'd0, o_defer_cnt}, 64'(m_cnt));
    endtask

    task automatic do_reset(input logic v, input logic [NP-1:0] m, input logic [TW-1:0] t);
        rst = 1'b1; i_ring_valid = v; i_ring_mask = m; i_ring_tag = t;
        i_tag_ready = 1'b0; i_defer_clr = 1'b0;
        @(posedge clk); #1;
        exp_q.delete(); m_cnt = 0;
        $display("[TB] reset with slot v=%0b m=%04h -> ov=%0b lvl=%0d", v, m, o_ring_valid, o_fifo_level);
        check("rst_ring_valid", {63'd0, o_ring_valid}, 64'd0);
        check("rst_ring_mask", {48'd0, o_ring_mask}, 64'd0);
        check("rst_ring_tag", {32'd0, o_ring_tag}, 64'd0);
        check("rst_tag_valid", {63'd0, o_tag_valid}, 64'd0);
        check("rst_tag_data", {32'd0, o_tag_data}, 64'd0);
        check("rst_level", {60'd0, o_fifo_level}, 64'd0);
        check("rst_defer", {60'd0, o_defer_cnt}, 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEP + 1; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic hit_rand(input logic [TW-1:0] t, input logic rdy);
        logic [NP-1:0] m;
        m = NP'($urandom) | NP'(1);
        cyc(1'b1, m, t, rdy, 1'b0);
    endtask

    initial begin
        do_reset(1'b0, '0, '0);
        do_reset(1'b0, '0, '0);

        // Single-destination tag is consumed and leaves the ring
        cyc(1'b1, 16'h0001, 32'hA5A5_0001, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Multi-destination tag: bit 0 cleared on forward, head held until ready
        cyc(1'b1, 16'h8003, 32'h0000_1234, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Pass-through of non-matching slots, including valid with empty mask
        cyc(1'b1, 16'h0F00, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(1'b1, 16'h0000, 32'h1111_2222, 1'b1, 1'b0);

        // Fill to DEPTH; ninth hit is deferred unchanged, then drain in order
        for (int i = 1; i <= 9; i++) cyc(1'b1, 16'h0001, 32'(i), 1'b0, 1'b0);
        drain();

        // Full with concurrent pop still defers; next hit is accepted
        for (int i = 0; i < DEP; i++) hit_rand(32'h100 + 32'(i), 1'b0);
        cyc(1'b1, 16'h0005, 32'h0000_0200, 1'b1, 1'b0);
        cyc(1'b1, 16'h0001, 32'h0000_0201, 1'b1, 1'b0);
        drain();

        // Steady state at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) hit_rand(32'h300 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) hit_rand(32'h400 + 32'(i), 1'b1);
        drain();

        // Defer counter saturation and clear priority
        for (int i = 0; i < DEP; i++) hit_rand(32'h500 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) hit_rand(32'h600 + 32'(i), 1'b0);
        cyc(1'b1, 16'h0001, 32'h0000_0700, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        drain();

        // Reset mid-operation with level 5 and a hit slot present
        for (int i = 0; i < 5; i++) hit_rand(32'h800 + 32'(i), 1'b0);
        do_reset(1'b1, 16'h0003, 32'h0000_0900);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, 16'h0001, 32'h0000_0A00, 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
